imem_loader: RTL and testbench



---
 rtl/imem_loader_if.sv | 24 ++
 rtl/imem_loader.sv | 151 +++++++++++++++
 tb/tb_imem_loader.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The loader (master) accepts stream bytes and drives the memory write
// port. The environment (slave) supplies bytes and observes the writes.
interface imem_loader_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int INSN_WIDTH = 40
);
   logic                  in_valid;
   logic [7:0]            in_data;
   logic                  in_ready;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [INSN_WIDTH-1:0] wr_data;

   modport master (
      input  in_valid, in_data,
      output in_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      output in_valid, in_data,
      input  in_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader.
// Reads a little-endian 16-bit word count followed by that many
// little-endian INSN_SIZE-byte instructions. Each instruction is written
// to consecutive word addresses starting at 0. The core is held in reset
// until the whole image has been written.
module imem_loader #(
   parameter int ADDR_WIDTH = 16,
   parameter int INSN_SIZE  = 5,
   parameter int INSN_WIDTH = INSN_SIZE * 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   imem_loader_if.master      bus,
   output logic               busy,
   output logic               done,
   output logic               hold_core
);

   localparam int BC_W = (INSN_SIZE > 1) ? $clog2(INSN_SIZE) : 1;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      DONE
   } state_t;

   state_t                 state;
   logic                   in_ready_q;
   logic                   wr_en_q;
   logic [ADDR_WIDTH-1:0]  wr_addr_q;
   logic [INSN_WIDTH-1:0]  wr_data_q;
   logic [7:0]             len_lo;
   logic [ADDR_WIDTH-1:0]  len_q;
   logic [ADDR_WIDTH-1:0]  word_cnt;
   logic [BC_W-1:0]        byte_cnt;
   // Holds the bytes of the word received so far; the newest byte sits at
   // the top so that the word is complete once the last byte arrives.
   logic [INSN_WIDTH-9:0]  asm_q;

   logic                   xfer;
   logic [ADDR_WIDTH-1:0]  hdr_len;
   logic [INSN_WIDTH-1:0]  word_full;
   logic                   last_byte;
   logic                   last_word;

   assign xfer      = bus.in_valid & in_ready_q;
   assign hdr_len   = ADDR_WIDTH'({bus.in_data, len_lo});
   assign word_full = {bus.in_data, asm_q};
   assign last_byte = (byte_cnt == BC_W'(INSN_SIZE - 1));
   assign last_word = (word_cnt == (len_q - ADDR_WIDTH'(1)));

   assign bus.in_ready = in_ready_q;
   assign bus.wr_en    = wr_en_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;

   // Load sequencer: header parse, word assembly, memory writes and status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         in_ready_q <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         hold_core  <= 1'b1;
         len_lo     <= '0;
         len_q      <= '0;
         word_cnt   <= '0;
         byte_cnt   <= '0;
         asm_q      <= '0;
      end else begin
         wr_en_q <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= LEN_LO;
                  in_ready_q <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            LEN_LO: begin
               if (xfer) begin
                  len_lo <= bus.in_data;
                  state  <= LEN_HI;
               end
            end
            LEN_HI: begin
               if (xfer) begin
                  len_q    <= hdr_len;
                  word_cnt <= '0;
                  byte_cnt <= '0;
                  if (hdr_len == '0) begin
                     // Empty image: release the core without any writes.
                     state      <= DONE;
                     in_ready_q <= 1'b0;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                     hold_core  <= 1'b0;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (xfer) begin
                  asm_q <= word_full[INSN_WIDTH-1:8];
                  if (last_byte) begin
                     wr_en_q   <= 1'b1;
                     wr_addr_q <= word_cnt;
                     wr_data_q <= word_full;
                     byte_cnt  <= '0;
                     word_cnt  <= word_cnt + ADDR_WIDTH'(1);
                     if (last_word) begin
                        // done lands with the final write strobe.
                        state      <= DONE;
                        in_ready_q <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        hold_core  <= 1'b0;
                     end
                  end else begin
                     byte_cnt <= byte_cnt + BC_W'(1);
                  end
               end
            end
            DONE: begin
               if (start) begin
                  state      <= LEN_LO;
                  in_ready_q <= 1'b1;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  hold_core  <= 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               in_ready_q <= 1'b0;
               busy       <= 1'b0;
               done       <= 1'b0;
               hold_core  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: idle after reset, full-rate load,
// empty image, stalled source, reset mid-load, ignored start and reload.
module tb_imem_loader;

   logic clk;
   logic reset;
   logic start;
   logic busy;
   logic done;
   logic hold_core;

   int n_cmp;
   int n_err;
   int wr_pulses;
   int stalls;

   imem_loader_if #(.ADDR_WIDTH(16), .INSN_WIDTH(40)) bus ();

   imem_loader #(.ADDR_WIDTH(16), .INSN_SIZE(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .bus       (bus),
      .busy      (busy),
      .done      (done),
      .hold_core (hold_core)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count every write strobe seen by the memory.
   always @(negedge clk) begin
      if (bus.wr_en === 1'b1) wr_pulses++;
   end

   // Hard stop in case the bench itself gets stuck.
   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Present one byte and hold it until it transfers (bounded wait).
   task automatic xfer(input logic [7:0] b);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      if (n == 20) check("xfer_ready", {63'd0, bus.in_ready}, 64'd1);
      step();
      stalls += n;
   endtask

   // Send one instruction, optionally with source gaps before each byte,
   // and check the single write strobe that follows the last byte.
   task automatic send_word(input string tag,
                            input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3,
                            input logic [7:0] b4,
                            input logic [15:0] addr, input logic [39:0] exp,
                            input int gap);
      logic [7:0] bs [5];
      bs = '{b0, b1, b2, b3, b4};
      for (int i = 0; i < 5; i++) begin
         if (gap > 0) begin
            bus.in_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
               step();
               check({tag, "_ready_in_gap"}, {63'd0, bus.in_ready}, 64'd1);
            end
         end
         xfer(bs[i]);
         if (i < 4) check({tag, "_no_early_wr"}, {63'd0, bus.wr_en}, 64'd0);
      end
      check({tag, "_wr_en"},   {63'd0, bus.wr_en}, 64'd1);
      check({tag, "_wr_addr"}, {48'd0, bus.wr_addr}, {48'd0, addr});
      check({tag, "_wr_data"}, {24'd0, bus.wr_data}, {24'd0, exp});
   endtask

   initial begin
      int base;
      n_cmp = 0;
      n_err = 0;
      wr_pulses = 0;
      stalls = 0;
      reset = 1'b1;
      start = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;

      // Reset then idle
      step();
      step();
      check("rst_wr_addr", {48'd0, bus.wr_addr}, 64'd0);
      check("rst_wr_data", {24'd0, bus.wr_data}, 64'd0);
      check("rst_hold",    {63'd0, hold_core}, 64'd1);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("idle_hold",  {63'd0, hold_core}, 64'd1);
         check("idle_busy",  {63'd0, busy}, 64'd0);
         check("idle_done",  {63'd0, done}, 64'd0);
         check("idle_ready", {63'd0, bus.in_ready}, 64'd0);
      end
      check("idle_no_writes", wr_pulses, 64'd0);

      // Two-word load at full rate
      pulse_start();
      check("load_busy",  {63'd0, busy}, 64'd1);
      check("load_ready", {63'd0, bus.in_ready}, 64'd1);
      stalls = 0;
      xfer(8'h02);
      xfer(8'h00);
      send_word("w0", 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 16'd0, 40'h5544332211, 0);
      check("w0_not_done", {63'd0, done}, 64'd0);
      send_word("w1", 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 16'd1, 40'hAA99887766, 0);
      check("w1_done", {63'd0, done}, 64'd1);
      check("w1_hold", {63'd0, hold_core}, 64'd0);
      check("w1_busy", {63'd0, busy}, 64'd0);
      check("full_rate_stalls", stalls, 64'd0);
      bus.in_valid = 1'b0;
      step();
      check("after_load_wr_en", {63'd0, bus.wr_en}, 64'd0);
      check("after_load_done",  {63'd0, done}, 64'd1);
      check("after_load_ready", {63'd0, bus.in_ready}, 64'd0);
      check("load_pulses", wr_pulses, 64'd2);

      // Zero-length image (also a reload from DONE)
      base = wr_pulses;
      pulse_start();
      check("zl_hold_reasserted", {63'd0, hold_core}, 64'd1);
      check("zl_done_cleared",    {63'd0, done}, 64'd0);
      xfer(8'h00);
      check("zl_done_early", {63'd0, done}, 64'd0);
      xfer(8'h00);
      bus.in_valid = 1'b0;
      check("zl_done", {63'd0, done}, 64'd1);
      check("zl_hold", {63'd0, hold_core}, 64'd0);
      step();
      step();
      check("zl_no_writes", wr_pulses - base, 64'd0);

      // Stalled source
      base = wr_pulses;
      pulse_start();
      xfer(8'h01);
      xfer(8'h00);
      send_word("stall", 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 16'd0, 40'hE5D4C3B2A1, 2);
      check("stall_done", {63'd0, done}, 64'd1);
      bus.in_valid = 1'b0;
      step();
      check("stall_pulses", wr_pulses - base, 64'd1);

      // Reset mid-operation
      base = wr_pulses;
      pulse_start();
      xfer(8'h03);
      xfer(8'h00);
      send_word("mid", 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 16'd0, 40'h0504030201, 0);
      xfer(8'h06);
      xfer(8'h07);
      bus.in_valid = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_rst_wr_en", {63'd0, bus.wr_en}, 64'd0);
      check("mid_rst_busy",  {63'd0, busy}, 64'd0);
      check("mid_rst_hold",  {63'd0, hold_core}, 64'd1);
      check("mid_rst_ready", {63'd0, bus.in_ready}, 64'd0);
      step();
      step();
      check("mid_rst_wr_en2", {63'd0, bus.wr_en}, 64'd0);
      check("mid_pulses", wr_pulses - base, 64'd1);
      pulse_start();
      xfer(8'h01);
      xfer(8'h00);
      send_word("mid_new", 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 16'd0, 40'h5040302010, 0);
      check("mid_new_done", {63'd0, done}, 64'd1);
      bus.in_valid = 1'b0;
      step();

      // Start during DATA is ignored; reload afterwards
      base = wr_pulses;
      pulse_start();
      xfer(8'h02);
      xfer(8'h00);
      xfer(8'h01);
      xfer(8'h02);
      bus.in_valid = 1'b0;
      pulse_start();
      check("ign_busy",  {63'd0, busy}, 64'd1);
      check("ign_ready", {63'd0, bus.in_ready}, 64'd1);
      xfer(8'h03);
      xfer(8'h04);
      xfer(8'h05);
      check("ign_wr_en",   {63'd0, bus.wr_en}, 64'd1);
      check("ign_wr_addr", {48'd0, bus.wr_addr}, 64'd0);
      check("ign_wr_data", {24'd0, bus.wr_data}, 64'h0504030201);
      send_word("ign_w1", 8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 16'd1, 40'hC4C3C2C1C0, 0);
      check("ign_done", {63'd0, done}, 64'd1);
      bus.in_valid = 1'b0;
      step();
      pulse_start();
      check("reload_hold", {63'd0, hold_core}, 64'd1);
      check("reload_done", {63'd0, done}, 64'd0);
      xfer(8'h01);
      xfer(8'h00);
      send_word("reload", 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h7F, 16'd0, 40'h7FEFBEADDE, 0);
      check("reload_done_end", {63'd0, done}, 64'd1);
      bus.in_valid = 1'b0;
      step();
      check("reload_pulses", wr_pulses - base, 64'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
